wavegen_multi_axis: RTL and testbench
=====================================

# wavegen_multi_axis

Synthesizable multi-channel AXI-Stream test-waveform generator. Next generation of the behavioural single-channel random-wave source used to drive the DSP subsystem stream input. Parametrised in sample width, phase width, channel count and frame length. Each channel has a run-time-selectable waveform (sawtooth, triangle, square, LFSR noise); channels are time-interleaved on one stream with channel ID and frame markers, so it serves both simulation benches and on-chip self-test.

## Interface
- `DW`, 16: sample width, 2..32.
- `PW`, 32: phase accumulator width, PW ≥ DW.
- `CH`, 2: channel count, ≥ 1.
- `FRAME_LEN`, 1024: sample sets per frame, ≥ 1. A set is one beat per channel.
- `LFSR_SEED`, 32'h1: noise LFSR reset value; must be non-zero.
- CHW = max(1, clog2(CH)).
- `aclk` in 1: clock.
- `aresetn` in 1: asynchronous active-low reset.
- `en` in 1: generator enable.
- `cfg_we` in 1: config write strobe, single cycle.
- `cfg_addr` in CHW+2: {channel, sel[1:0]}. sel values:
  - 0: phase_inc.
  - 1: mode, bits [1:0].
  - 2: phase load.
  - 3: ignored.
- `cfg_wdata` in 32: write data, LSBs used.
- `tdata_m_o` out DW: sample, two's complement.
- `tvalid_m_o` out 1: stream valid.
- `tready_m_i` in 1: stream ready.
- `tid_m_o` out CHW: channel of the current beat.
- `tuser_m_o` out 1: first beat of a frame.
- `tlast_m_o` out 1: last beat of a frame.

## Operation
- Per-channel state:
  - phase[PW], reset 0.
  - inc[PW], reset 0.
  - mode[2], reset 0 (sawtooth).
- Shared 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, reset LFSR_SEED.
- Beat counters: ch_idx (0..CH-1) and set_cnt (0..FRAME_LEN-1), both reset 0.
- Sample for channel k, with p = phase[k][PW-1 -: DW] and m = 1<<(DW-1):
  - mode 0, saw: p ^ m.
  - mode 1, triangle: t = p[DW-1] ? ~{p[DW-2:0],0} : {p[DW-2:0],0}; output t ^ m.
  - mode 2, square: p[DW-1]=0 → m-1, else m.
  - mode 3, noise: lfsr[DW-1:0].
- The output register holds the sample computed from the pre-advance phase.
- On loading channel k into the output register:
  - phase[k] += inc[k], mod 2^PW.
  - If mode[k]=3, the LFSR advances one step.
- Beat sequencing:
  - ch_idx increments per handshake and wraps CH-1→0.
  - set_cnt increments when ch_idx wraps, and wraps FRAME_LEN-1→0.
  - tuser = (ch_idx==0 && set_cnt==0).
  - tlast = (ch_idx==CH-1 && set_cnt==FRAME_LEN-1).
- Config writes:
  - Land the cycle after cfg_we.
  - Affect the next sample loaded for that channel; never the beat already held in the output register.
  - Writes to a channel ≥ CH are ignored.
  - Phase load (sel 2) sets phase[k] = cfg_wdata zero-extended or truncated to PW.
  - If a phase load coincides with that channel's advance, the load wins.
- Enable:
  - en=0 leaves counters and phases frozen once the output is empty.
  - en does not clear state; only reset does.

## Timing
- Reset values: tvalid_m_o=0, tdata_m_o=0, tid_m_o=0, tuser_m_o=0, tlast_m_o=0.
- Reset is asynchronous: a mid-stream assertion clears all outputs immediately, even while tvalid=1.
- Start-up: en high in cycle n → tvalid=1 in cycle n+1 with channel 0, phase 0.
- Throughput: one beat per cycle while tready=1. The next sample is loaded on the same edge as the handshake.
- Back-pressure: while tvalid=1 and tready=0, tdata/tid/tuser/tlast are stable and no phase, LFSR or counter advances.
- en falling: tvalid is never withdrawn without a handshake.
  - The pending beat stays valid until accepted.
  - tvalid falls the cycle after that handshake if en is still 0.
- en rising while idle: the output reloads from the frozen ch_idx/set_cnt, so frame alignment is preserved across gaps.

## Test plan
- Reset, then configure DW=16, CH=2, FRAME_LEN=4, inc0=0x10000000 (saw), inc1=0, en=1, tready=1.
  - Expect tid 0,1,0,1,…
  - ch0 samples 0x8000, 0x9000, 0xA000, …; ch1 constant 0x8000.
- Square on ch1 with inc1=0x40000000 → ch1 beats 0x7FFF, 0x7FFF, 0x8000, 0x8000, repeating.
- Triangle on ch0 with inc0=0x20000000 → 0x8000, 0xC000, 0x0000, 0x4000, 0x7FFF, 0x3FFF, …
- Framing and back-pressure:
  - Over 16 accepted beats, tuser is high only on beats 0 and 8; tlast only on beats 7 and 15.
  - Hold tready=0 for 5 cycles mid-frame → outputs stable, and the sequence resumes unchanged.
- Control events:
  - Drop en during back-pressure → the beat is held until tready, then tvalid=0.
  - Phase load 0 on ch0 → its next loaded sample is 0x8000.
- Asynchronous reset mid-stream with tvalid=1 → outputs zero before the next edge; after release and en=1, the first beat is ch0 at phase 0 with tuser=1.

Source files
------------

// File: rtl/wavegen_multi_axis.sv
// wavegen_multi_axis: multi-channel AXI-Stream test-waveform generator.
// Time-interleaved saw/triangle/square/noise channels with tid/tuser/tlast.
//
// Ports:
//   aclk, aresetn           clock, async active-low reset
//   en                      generator enable
//   cfg_we/cfg_addr/wdata   config write, addr = {channel, sel[1:0]}
//   tdata/tvalid/tready_m   stream sample handshake
//   tid_m_o                 channel of the current beat
//   tuser_m_o / tlast_m_o   first / last beat of a frame
module wavegen_multi_axis #(
   parameter int          DW        = 16,
   parameter int          PW        = 32,
   parameter int          CH        = 2,
   parameter int          FRAME_LEN = 1024,
   parameter logic [31:0] LFSR_SEED = 32'h1,
   localparam int         CHW       = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic           aclk,
   input  logic           aresetn,
   input  logic           en,
   input  logic           cfg_we,
   input  logic [CHW+1:0] cfg_addr,
   input  logic [31:0]    cfg_wdata,
   output logic [DW-1:0]  tdata_m_o,
   output logic           tvalid_m_o,
   input  logic           tready_m_i,
   output logic [CHW-1:0] tid_m_o,
   output logic           tuser_m_o,
   output logic           tlast_m_o
);

   localparam int SW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [DW-1:0] MSB = {1'b1, {(DW-1){1'b0}}};

   logic [PW-1:0]  phase [CH];
   logic [PW-1:0]  inc   [CH];
   logic [1:0]     mode  [CH];
   logic [31:0]    lfsr;
   logic [31:0]    lfsr_nx;
   logic [CHW-1:0] ch_idx;
   logic [SW-1:0]  set_cnt;

   logic           load;
   logic [CHW-1:0] wch;
   logic [1:0]     wsel;
   logic           wok;
   logic [DW-1:0]  p;
   logic [DW-1:0]  sh;
   logic [DW-1:0]  tri_v;
   logic [DW-1:0]  smp;
   logic [1:0]     cur_md;
   logic           first;
   logic           last;

   // The output register reloads whenever it is empty or being drained.
   assign load = en && (!tvalid_m_o || tready_m_i);

   assign wsel = cfg_addr[1:0];
   assign wch  = cfg_addr[CHW+1:2];
   assign wok  = cfg_we && (32'(wch) < CH);

   assign first = (ch_idx == '0) && (set_cnt == '0);
   assign last  = (ch_idx == CHW'(CH-1)) &&
                  (set_cnt == SW'(FRAME_LEN-1));

   // Galois LFSR, x^32 + x^22 + x^2 + x + 1
   assign lfsr_nx = {1'b0, lfsr[31:1]} ^
                    (lfsr[0] ? 32'h8020_0003 : 32'h0);

   always_comb begin
      p      = '0;
      cur_md = '0;
      for (int k = 0; k < CH; k++) begin
         if (ch_idx == CHW'(k)) begin
            p      = phase[k][PW-1 -: DW];
            cur_md = mode[k];
         end
      end
      sh    = {p[DW-2:0], 1'b0};
      tri_v = p[DW-1] ? ~sh : sh;
      case (cur_md)
         2'd0:    smp = p ^ MSB;
         2'd1:    smp = tri_v ^ MSB;
         2'd2:    smp = p[DW-1] ? MSB : ~MSB;
         default: smp = lfsr[DW-1:0];
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         tvalid_m_o <= 1'b0;
         tdata_m_o  <= '0;
         tid_m_o    <= '0;
         tuser_m_o  <= 1'b0;
         tlast_m_o  <= 1'b0;
         ch_idx     <= '0;
         set_cnt    <= '0;
         lfsr       <= LFSR_SEED;
      end else begin
         if (load) begin
            tvalid_m_o <= 1'b1;
            tdata_m_o  <= smp;
            tid_m_o    <= ch_idx;
            tuser_m_o  <= first;
            tlast_m_o  <= last;
            // counters point at the next beat to load
            if (ch_idx == CHW'(CH-1)) begin
               ch_idx <= '0;
               if (set_cnt == SW'(FRAME_LEN-1))
                  set_cnt <= '0;
               else
                  set_cnt <= set_cnt + 1'b1;
            end else begin
               ch_idx <= ch_idx + 1'b1;
            end
            if (cur_md == 2'd3)
               lfsr <= lfsr_nx;
         end else if (tready_m_i) begin
            tvalid_m_o <= 1'b0;
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int k = 0; k < CH; k++) begin
            phase[k] <= '0;
            inc[k]   <= '0;
            mode[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < CH; k++) begin
            // a phase load beats the advance on the same edge
            if (wok && wch == CHW'(k) && wsel == 2'd2)
               phase[k] <= PW'(cfg_wdata);
            else if (load && ch_idx == CHW'(k))
               phase[k] <= phase[k] + inc[k];
            if (wok && wch == CHW'(k) && wsel == 2'd0)
               inc[k] <= PW'(cfg_wdata);
            if (wok && wch == CHW'(k) && wsel == 2'd1)
               mode[k] <= cfg_wdata[1:0];
         end
      end
   end

endmodule

// File: tb/tb_wavegen_multi_axis.sv
// tb_wavegen_multi_axis: directed bench for wavegen_multi_axis.
// DW=16, CH=2, FRAME_LEN=4; saw, triangle, square, framing, control.
module tb_wavegen_multi_axis;

   logic        aclk;
   logic        aresetn;
   logic        en;
   logic        cfg_we;
   logic [2:0]  cfg_addr;
   logic [31:0] cfg_wdata;
   logic [15:0] tdata;
   logic        tvalid;
   logic        tready;
   logic [0:0]  tid;
   logic        tuser;
   logic        tlast;

   int n_chk  = 0;
   int n_fail = 0;

   logic [15:0] exp1 [16] = '{
      16'h8000, 16'h8000, 16'h9000, 16'h8000,
      16'hA000, 16'h8000, 16'hB000, 16'h8000,
      16'hC000, 16'h8000, 16'hD000, 16'h8000,
      16'hE000, 16'h8000, 16'hF000, 16'h8000};

   logic [15:0] exp2 [16] = '{
      16'h8000, 16'h7FFF, 16'hC000, 16'h7FFF,
      16'h0000, 16'h8000, 16'h4000, 16'h8000,
      16'h7FFF, 16'h7FFF, 16'h3FFF, 16'h7FFF,
      16'h8000, 16'h8000, 16'hC000, 16'h8000};

   wavegen_multi_axis #(
      .DW(16), .PW(32), .CH(2), .FRAME_LEN(4),
      .LFSR_SEED(32'h1)
   ) dut (
      .aclk(aclk),
      .aresetn(aresetn),
      .en(en),
      .cfg_we(cfg_we),
      .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata),
      .tdata_m_o(tdata),
      .tvalid_m_o(tvalid),
      .tready_m_i(tready),
      .tid_m_o(tid),
      .tuser_m_o(tuser),
      .tlast_m_o(tlast)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic beat(input string tag, input int id,
                       input logic [15:0] d,
                       input logic u, input logic l);
      chk({tag, " tvalid"}, 32'(tvalid), 32'd1);
      chk({tag, " tid"},    32'(tid),    32'(id));
      chk({tag, " tdata"},  32'(tdata),  32'(d));
      chk({tag, " tuser"},  32'(tuser),  32'(u));
      chk({tag, " tlast"},  32'(tlast),  32'(l));
   endtask

   task automatic cfg(input logic [2:0] a, input logic [31:0] d);
      cfg_we    = 1'b1;
      cfg_addr  = a;
      cfg_wdata = d;
      @(negedge aclk);
      cfg_we    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      aresetn   = 1'b0;
      en        = 1'b0;
      cfg_we    = 1'b0;
      cfg_addr  = '0;
      cfg_wdata = '0;
      tready    = 1'b1;
      repeat (2) @(negedge aclk);
      chk("rst tvalid", 32'(tvalid), 32'd0);
      chk("rst tdata",  32'(tdata),  32'd0);
      chk("rst tid",    32'(tid),    32'd0);
      chk("rst tuser",  32'(tuser),  32'd0);
      chk("rst tlast",  32'(tlast),  32'd0);
      aresetn = 1'b1;

      // sawtooth on ch0, ch1 flat
      cfg(3'd0, 32'h1000_0000);
      chk("idle1 tvalid", 32'(tvalid), 32'd0);
      en = 1'b1;
      @(negedge aclk);
      for (int b = 0; b < 16; b++) begin
         beat($sformatf("saw b%0d", b), b % 2, exp1[b],
              (b % 8) == 0, (b % 8) == 7);
         if (b == 15) en = 1'b0;
         @(negedge aclk);
      end
      chk("saw stop tvalid", 32'(tvalid), 32'd0);

      // triangle on ch0, square on ch1
      cfg(3'd1, 32'd1);
      cfg(3'd0, 32'h2000_0000);
      cfg(3'd2, 32'd0);
      cfg(3'd5, 32'd2);
      cfg(3'd4, 32'h4000_0000);
      chk("idle2 tvalid", 32'(tvalid), 32'd0);
      en = 1'b1;
      @(negedge aclk);
      for (int b = 0; b < 16; b++) begin
         cfg_we = 1'b0;
         beat($sformatf("tri b%0d", b), b % 2, exp2[b],
              (b % 8) == 0, (b % 8) == 7);
         if (b == 5) begin
            tready = 1'b0;
            for (int i = 0; i < 5; i++) begin
               @(negedge aclk);
               beat($sformatf("hold%0d", i), 1, exp2[5],
                    1'b0, 1'b0);
            end
            tready = 1'b1;
         end
         if (b == 9) begin
            cfg_we    = 1'b1;
            cfg_addr  = 3'd2;
            cfg_wdata = 32'd0;
         end
         if (b == 15) begin
            tready = 1'b0;
            en     = 1'b0;
            for (int i = 0; i < 3; i++) begin
               @(negedge aclk);
               beat($sformatf("enhold%0d", i), 1, exp2[15],
                    1'b0, 1'b1);
            end
            tready = 1'b1;
         end
         @(negedge aclk);
      end
      cfg_we = 1'b0;
      chk("en drop tvalid", 32'(tvalid), 32'd0);
      @(negedge aclk);
      chk("idle3 tvalid", 32'(tvalid), 32'd0);

      // restart keeps frame alignment, then async reset
      en = 1'b1;
      @(negedge aclk);
      beat("resume b0", 0, 16'h0000, 1'b1, 1'b0);
      @(negedge aclk);
      beat("resume b1", 1, 16'h7FFF, 1'b0, 1'b0);
      #2 aresetn = 1'b0;
      #1;
      chk("arst tvalid", 32'(tvalid), 32'd0);
      chk("arst tdata",  32'(tdata),  32'd0);
      chk("arst tid",    32'(tid),    32'd0);
      chk("arst tuser",  32'(tuser),  32'd0);
      chk("arst tlast",  32'(tlast),  32'd0);
      @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      beat("post rst b0", 0, 16'h8000, 1'b1, 1'b0);
      @(negedge aclk);
      beat("post rst b1", 1, 16'h8000, 1'b0, 1'b0);
      en = 1'b0;
      @(negedge aclk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
